// File: rtl/sdram_arbiter_mp_pkg.sv
// Shared types and width helpers for the multi-port SDRAM arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // Both widths are clamped to one bit so degenerate parameter values still elaborate.
  function automatic int cntWidth(input int opCycles);
    return (opCycles <= 2) ? 1 : $clog2(opCycles);
  endfunction

  function automatic int idxWidth(input int nClient);
    return (nClient <= 2) ? 1 : $clog2(nClient);
  endfunction

endpackage

// File: rtl/sdram_arbiter_mp_rr_picker.sv
// Round-robin priority encoder: returns the first requester strictly after 'last', cyclically.
module rr_picker
  import sdram_arb_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // The search runs from the farthest slot back to the nearest, so the nearest requester wins.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int k = N; k >= 1; k--) begin
      for (int j = 0; j < N; j++) begin
        if (req_i[j] && (j == ((int'(last_i) + k) % N))) begin
          idx_o = IDX_W'(j);
          any_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter_mp.sv
// Shares one SDRAM controller port between a zero-latency Mac host and NCLIENT round-robin clients.
module sdram_arbiter_mp
  import sdram_arb_pkg::*;
#(
  parameter int NCLIENT   = 2,
  parameter int AW        = 25,
  parameter int DW        = 16,
  parameter int OP_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [AW-1:0]         host_addr,
  input  logic [DW-1:0]         host_din,
  output logic [DW-1:0]         host_dout,
  input  logic [1:0]            host_ds,
  input  logic                  host_we,
  input  logic                  host_oe,
  input  logic [NCLIENT-1:0]    cli_req,
  input  logic [NCLIENT-1:0]    cli_we,
  input  logic [NCLIENT*AW-1:0] cli_addr,
  input  logic [NCLIENT*DW-1:0] cli_wdata,
  input  logic [NCLIENT*2-1:0]  cli_ds,
  output logic [NCLIENT-1:0]    cli_ack,
  output logic [DW-1:0]         cli_rdata,
  output logic                  busy,
  output logic [7:0]            preempt_cnt,
  output logic [AW-1:0]         sdram_addr,
  output logic [DW-1:0]         sdram_din,
  output logic [1:0]            sdram_ds,
  output logic                  sdram_we,
  output logic                  sdram_oe,
  input  logic [DW-1:0]         sdram_dout
);

  localparam int CNT_W = cntWidth(OP_CYCLES);
  localparam int IDX_W = idxWidth(NCLIENT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCLIENT - 1);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   gnt_q;
  logic [IDX_W-1:0]   rrLast_q;
  logic               hostPrev_q;
  logic [7:0]         preemptCnt_q;
  logic [7:0]         preemptCnt_d;
  logic [NCLIENT-1:0] ack_q;
  logic [DW-1:0]      rdata_q;
  logic               busy_q;

  logic               hostActive;
  logic [IDX_W-1:0]   pickIdx;
  logic               pickAny;

  logic [AW-1:0] cAddr  [NCLIENT];
  logic [DW-1:0] cWdata [NCLIENT];
  logic [1:0]    cDs    [NCLIENT];

  for (genvar i = 0; i < NCLIENT; i++) begin : g_unpack
    assign cAddr[i]  = cli_addr[i*AW +: AW];
    assign cWdata[i] = cli_wdata[i*DW +: DW];
    assign cDs[i]    = cli_ds[i*2 +: 2];
  end

  rr_picker #(
    .N     (NCLIENT),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_i  (cli_req),
    .last_i (rrLast_q),
    .idx_o  (pickIdx),
    .any_o  (pickAny)
  );

  assign hostActive   = host_we | host_oe;
  assign preemptCnt_d = (preemptCnt_q == 8'hFF) ? preemptCnt_q : preemptCnt_q + 8'd1;

  // Host owns the controller port whenever it is active or no client op is in flight.
  always_comb begin
    sdram_addr = host_addr;
    sdram_din  = host_din;
    sdram_ds   = host_ds;
    sdram_we   = host_we;
    sdram_oe   = host_oe;
    if (!hostActive && (state_q == BUSY)) begin
      sdram_addr = cAddr[gnt_q];
      sdram_din  = cWdata[gnt_q];
      sdram_ds   = cDs[gnt_q];
      sdram_we   = cli_we[gnt_q];
      sdram_oe   = ~cli_we[gnt_q];
    end
  end

  // A host access during BUSY restarts the client op; only the rising edge counts as a preemption.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      gnt_q        <= '0;
      rrLast_q     <= IDX_LAST;
      hostPrev_q   <= 1'b0;
      preemptCnt_q <= 8'd0;
      ack_q        <= '0;
      rdata_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      hostPrev_q <= hostActive;
      ack_q      <= '0;
      case (state_q)
        IDLE: begin
          if (!hostActive && pickAny) begin
            gnt_q   <= pickIdx;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (hostActive) begin
            cnt_q <= '0;
            if (!hostPrev_q) preemptCnt_q <= preemptCnt_d;
          end else if (cnt_q == CNT_LAST) begin
            if (!cli_we[gnt_q]) rdata_q <= sdram_dout;
            rrLast_q      <= gnt_q;
            ack_q[gnt_q]  <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cli_ack     = ack_q;
  assign cli_rdata   = rdata_q;
  assign busy        = busy_q;
  assign preempt_cnt = preemptCnt_q;
  assign host_dout   = sdram_dout;

endmodule

// File: tb/tb_sdram_arbiter_mp.sv
// Directed self-checking bench for sdram_arbiter_mp with two clients and a four-cycle SDRAM op.
module tb_sdram_arbiter_mp;

  localparam int NCLIENT   = 2;
  localparam int AW        = 25;
  localparam int DW        = 16;
  localparam int OP_CYCLES = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [AW-1:0]         hostAddr;
  logic [DW-1:0]         hostDin;
  logic [DW-1:0]         hostDout;
  logic [1:0]            hostDs;
  logic                  hostWe;
  logic                  hostOe;
  logic [NCLIENT-1:0]    cliReq;
  logic [NCLIENT-1:0]    cliWe;
  logic [NCLIENT*AW-1:0] cliAddr;
  logic [NCLIENT*DW-1:0] cliWdata;
  logic [NCLIENT*2-1:0]  cliDs;
  logic [NCLIENT-1:0]    cliAck;
  logic [DW-1:0]         cliRdata;
  logic                  busy;
  logic [7:0]            preemptCnt;
  logic [AW-1:0]         sdramAddr;
  logic [DW-1:0]         sdramDin;
  logic [1:0]            sdramDs;
  logic                  sdramWe;
  logic                  sdramOe;
  logic [DW-1:0]         sdramDout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Controller model: read data is an address-dependent pattern so a wrong address mux shows up.
  assign sdramDout = sdramOe ? (16'hBEEF ^ sdramAddr[15:0]) : 16'hDEAD;

  sdram_arbiter_mp #(
    .NCLIENT   (NCLIENT),
    .AW        (AW),
    .DW        (DW),
    .OP_CYCLES (OP_CYCLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .host_addr   (hostAddr),
    .host_din    (hostDin),
    .host_dout   (hostDout),
    .host_ds     (hostDs),
    .host_we     (hostWe),
    .host_oe     (hostOe),
    .cli_req     (cliReq),
    .cli_we      (cliWe),
    .cli_addr    (cliAddr),
    .cli_wdata   (cliWdata),
    .cli_ds      (cliDs),
    .cli_ack     (cliAck),
    .cli_rdata   (cliRdata),
    .busy        (busy),
    .preempt_cnt (preemptCnt),
    .sdram_addr  (sdramAddr),
    .sdram_din   (sdramDin),
    .sdram_ds    (sdramDs),
    .sdram_we    (sdramWe),
    .sdram_oe    (sdramOe),
    .sdram_dout  (sdramDout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input logic oe, input logic [AW-1:0] addr,
                               input logic [NCLIENT-1:0] req);
    hostWe   = we;
    hostOe   = oe;
    hostAddr = addr;
    cliReq   = req;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset    = 1'b1;
    hostDin  = 16'h0000;
    hostDs   = 2'b11;
    cliWe    = 2'b00;
    cliAddr  = {25'h00000F0, 25'h0000000};
    cliWdata = {16'hA5A5, 16'h0000};
    cliDs    = {2'b10, 2'b01};
    applyStimulus(1'b0, 1'b0, 25'h0000042, 2'b00);
    tick();
    tick();
    reset = 1'b0;
    #1;

    $display("[TB] reset state");
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_ack", 32'(cliAck), 32'h0);
    checkOutput("rst_rdata", 32'(cliRdata), 32'h0);
    checkOutput("rst_preempt", 32'(preemptCnt), 32'h0);
    checkOutput("rst_passthru_addr", 32'(sdramAddr), 32'h42);

    $display("[TB] single client0 read");
    applyStimulus(1'b0, 1'b0, 25'h0000042, 2'b01);
    tick();
    checkOutput("t1_busy", 32'(busy), 32'h1);
    checkOutput("t1_cli_addr", 32'(sdramAddr), 32'h0);
    checkOutput("t1_cli_oe", 32'(sdramOe), 32'h1);
    checkOutput("t1_cli_ds", 32'(sdramDs), 32'h1);
    tick();
    tick();
    tick();
    checkOutput("t1_no_early_ack", 32'(cliAck), 32'h0);
    tick();
    checkOutput("t1_ack", 32'(cliAck), 32'h1);
    checkOutput("t1_rdata", 32'(cliRdata), 32'hBEEF);
    checkOutput("t1_busy_done", 32'(busy), 32'h0);
    applyStimulus(1'b0, 1'b0, 25'h0000042, 2'b00);
    tick();
    checkOutput("t1_ack_pulse", 32'(cliAck), 32'h0);

    $display("[TB] two clients alternate");
    applyStimulus(1'b0, 1'b0, 25'h0000042, 2'b11);
    for (int n = 0; n < 4; n++) begin
      int wait_cycles;
      logic [1:0] expAck;
      logic [15:0] expData;
      expAck  = (n % 2 == 0) ? 2'b10 : 2'b01;
      expData = (n % 2 == 0) ? 16'hBE1F : 16'hBEEF;
      wait_cycles = 0;
      do begin
        tick();
        wait_cycles++;
      end while ((cliAck === 2'b00) && (wait_cycles < 12));
      checkOutput("t2_alt_ack", 32'(cliAck), 32'(expAck));
      checkOutput("t2_alt_rdata", 32'(cliRdata), 32'(expData));
    end
    applyStimulus(1'b0, 1'b0, 25'h0000042, 2'b00);
    tick();
    tick();
    checkOutput("t2_idle_after", 32'(busy), 32'h0);

    $display("[TB] host preempts client1 write");
    cliWe    = 2'b10;
    cliAddr  = {25'h0001234, 25'h0000000};
    cliDs    = {2'b11, 2'b01};
    applyStimulus(1'b0, 1'b0, 25'h0000042, 2'b10);
    tick();
    checkOutput("t3_wr_we", 32'(sdramWe), 32'h1);
    checkOutput("t3_wr_addr", 32'(sdramAddr), 32'h1234);
    checkOutput("t3_wr_din", 32'(sdramDin), 32'hA5A5);
    tick();
    tick();
    hostDs = 2'b01;
    applyStimulus(1'b0, 1'b1, 25'h00ABCDE, 2'b10);
    checkOutput("t3_host_addr", 32'(sdramAddr), 32'hABCDE);
    checkOutput("t3_host_oe", 32'(sdramOe), 32'h1);
    checkOutput("t3_host_we", 32'(sdramWe), 32'h0);
    checkOutput("t3_host_ds", 32'(sdramDs), 32'h1);
    checkOutput("t3_host_dout", 32'(hostDout), 32'h0231);
    tick();
    checkOutput("t3_preempt1", 32'(preemptCnt), 32'h1);
    tick();
    checkOutput("t3_preempt_once", 32'(preemptCnt), 32'h1);
    applyStimulus(1'b0, 1'b0, 25'h00ABCDE, 2'b10);
    tick();
    tick();
    tick();
    checkOutput("t3_restart_no_ack", 32'(cliAck), 32'h0);
    tick();
    checkOutput("t3_ack", 32'(cliAck), 32'h2);
    checkOutput("t3_wr_keeps_rdata", 32'(cliRdata), 32'hBEEF);
    applyStimulus(1'b0, 1'b0, 25'h00ABCDE, 2'b00);
    tick();

    $display("[TB] host and client collide in IDLE");
    hostDin = 16'h1111;
    hostDs  = 2'b11;
    applyStimulus(1'b1, 1'b0, 25'h0000155, 2'b01);
    checkOutput("t4_addr", 32'(sdramAddr), 32'h155);
    checkOutput("t4_din", 32'(sdramDin), 32'h1111);
    tick();
    checkOutput("t4_busy", 32'(busy), 32'h0);
    checkOutput("t4_ack", 32'(cliAck), 32'h0);
    tick();
    checkOutput("t4_busy_hold", 32'(busy), 32'h0);
    checkOutput("t4_preempt_same", 32'(preemptCnt), 32'h1);
    applyStimulus(1'b0, 1'b0, 25'h0000155, 2'b01);
    tick();
    checkOutput("t4_grant_after", 32'(busy), 32'h1);
    tick();

    $display("[TB] reset mid-op");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("t5_busy", 32'(busy), 32'h0);
    checkOutput("t5_ack", 32'(cliAck), 32'h0);
    checkOutput("t5_preempt", 32'(preemptCnt), 32'h0);
    checkOutput("t5_rdata", 32'(cliRdata), 32'h0);
    cliWe   = 2'b00;
    cliAddr = {25'h00000F0, 25'h0000000};
    applyStimulus(1'b0, 1'b0, 25'h0000155, 2'b11);
    tick();
    tick();
    tick();
    tick();
    tick();
    checkOutput("t5_prio_ack0", 32'(cliAck), 32'h1);
    applyStimulus(1'b0, 1'b0, 25'h0000155, 2'b10);
    tick();
    tick();
    tick();
    tick();
    tick();
    checkOutput("t5_no_early_ack1", 32'(cliAck), 32'h0);
    tick();
    checkOutput("t5_ack1", 32'(cliAck), 32'h2);
    checkOutput("t5_rdata1", 32'(cliRdata), 32'hBE1F);
    applyStimulus(1'b0, 1'b0, 25'h0000155, 2'b00);
    tick();

    $display("[TB] preemption counter saturates");
    applyStimulus(1'b0, 1'b0, 25'h0000155, 2'b01);
    tick();
    for (int n = 0; n < 254; n++) begin
      applyStimulus(1'b0, 1'b1, 25'h0000155, 2'b01);
      tick();
      applyStimulus(1'b0, 1'b0, 25'h0000155, 2'b01);
      tick();
    end
    checkOutput("t6_preempt_fe", 32'(preemptCnt), 32'hFE);
    for (int n = 0; n < 10; n++) begin
      applyStimulus(1'b0, 1'b1, 25'h0000155, 2'b01);
      tick();
      applyStimulus(1'b0, 1'b0, 25'h0000155, 2'b01);
      tick();
    end
    checkOutput("t6_preempt_sat", 32'(preemptCnt), 32'hFF);
    checkOutput("t6_still_busy", 32'(busy), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
